output_fifo_unit: RTL and testbench

OUTPUT_FIFO_UNIT -- requirements
Module: output_fifo_unit

---
 rtl/output_fifo_unit_if.sv | 53 +++++
 rtl/output_fifo_unit.sv | 133 +++++++++++++
 tb/tb_output_fifo_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/output_fifo_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : output_fifo_unit_if
//  Description : Bundles the output FIFO unit signals into one interface.
//                The CPU side is a request/acknowledge handshake. The sink
//                side is a valid/ready stream. Occupancy status is exported.
//  Ports       : master modport - CPU/sink side (drives out_req, out_data,
//                                 tx_ready)
//                slave modport  - FIFO unit side (drives out_ack, tx_valid,
//                                 tx_data, level, full, empty)
//  Revision    : 1.0  initial release
// ============================================================================
interface output_fifo_unit_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             out_req;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;

    modport master (
        output out_req,
        output out_data,
        output tx_ready,
        input  out_ack,
        input  tx_valid,
        input  tx_data,
        input  level,
        input  full,
        input  empty
    );

    modport slave (
        input  out_req,
        input  out_data,
        input  tx_ready,
        output out_ack,
        output tx_valid,
        output tx_data,
        output level,
        output full,
        output empty
    );
endinterface
`default_nettype wire

// File: rtl/output_fifo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : output_fifo_unit
//  Description : Accepts words from the CPU with a three-state handshake:
//                IDLE, then ACK, then RELEASE. Each request writes exactly
//                one word. Stored words are presented to a downstream sink
//                through a first-word-fall-through FIFO.
//  Ports       : clk   - clock. All state updates on the rising edge.
//                rst_b - asynchronous reset, active-high.
//                bus   - output_fifo_unit_if.slave:
//                        out_req/out_data/out_ack carry the CPU handshake.
//                        tx_valid/tx_data/tx_ready carry the sink stream.
//                        level/full/empty report FIFO occupancy.
//  Revision    : 1.0  initial release
// ============================================================================
module output_fifo_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_b,
    output_fifo_unit_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0] C_LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] C_LVL_DEPTH = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_write;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             r_out_ack;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign w_full  = (r_level == C_LVL_DEPTH);
    assign w_empty = (r_level == '0);
    // A pop needs a visible word, so tx_ready while empty has no effect.
    assign w_pop   = !w_empty && bus.tx_ready;

    // Handshake next-state logic. A write happens only when the FSM leaves
    // IDLE. The FSM must then see out_req low before it returns to IDLE,
    // so a long request still writes only one word.
    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A pop on this same edge does not unblock a full FIFO,
                // because full is evaluated before the edge.
                if (bus.out_req && !w_full) begin
                    w_write     = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus.out_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // out_ack comes from its own flop. It is high exactly during the
    // cycle the FSM spends in ACK.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state   <= ST_IDLE;
            r_out_ack <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_ack <= w_write;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. Level cannot
    // overflow, because writes are gated by full. It cannot underflow,
    // because pops are gated by empty.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_write, w_pop})
                2'b10:   r_level <= r_level + C_LVL_ONE;
                2'b01:   r_level <= r_level - C_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset. Pointer and level reset alone make old contents
    // unreachable.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= bus.out_data;
        end
    end

    assign bus.out_ack  = r_out_ack;
    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.level    = r_level;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
endmodule
`default_nettype wire

// File: tb/tb_output_fifo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_fifo_unit
//  Description : Self-checking bench for output_fifo_unit. A queue-based
//                reference model predicts the acknowledge and the FIFO
//                contents on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_output_fifo_unit;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;

    output_fifo_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    output_fifo_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc   = 0;
    logic [WIDTH-1:0] q [$];    // expected FIFO contents, head at index 0
    logic [WIDTH-1:0] rx [$];   // words actually handed to the sink
    bit               m_ack  = 1'b0;  // acknowledge expected this cycle
    bit               m_busy = 1'b0;  // current request already served

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [WIDTH-1:0] head;
        head = '0;
        if (q.size() != 0) head = q[0];
        chk("out_ack",  32'(bus.out_ack),  32'(m_ack));
        chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
        chk("tx_data",  32'(bus.tx_data),  32'(head));
        chk("level",    32'(bus.level),    32'(q.size()));
        chk("full",     32'(bus.full),     32'(q.size() == DEPTH));
        chk("empty",    32'(bus.empty),    32'(q.size() == 0));
    endtask

    // One clock cycle. The task checks the outputs, drives the inputs, and
    // then advances the model across the rising edge.
    task automatic tick(input bit req, input logic [WIDTH-1:0] data, input bit ready);
        bit wr;
        bit pop;
        check_outputs();
        bus.out_req  = req;
        bus.out_data = data;
        bus.tx_ready = ready;
        if (bus.tx_valid && ready) rx.push_back(bus.tx_data);
        pop = (q.size() != 0) && ready;
        wr  = req && !m_busy && (q.size() < DEPTH);
        @(posedge clk);
        cyc++;
        if (pop) void'(q.pop_front());
        if (wr)  q.push_back(data);
        // One request yields one write. A new write needs the acknowledge
        // cycle to have passed and the request to have been seen low.
        if (wr) m_busy = 1'b1;
        else if (m_busy && !m_ack && !req) m_busy = 1'b0;
        m_ack = wr;
        @(negedge clk);
    endtask

    function automatic bit rdy(input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return cyc[0];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic send_word(input logic [WIDTH-1:0] data, input int mode);
        int n;
        n = 0;
        while (!m_ack && n < 40) begin
            tick(1'b1, data, rdy(mode));
            n++;
        end
        if (!m_ack) begin
            n_cmp++;
            n_err++;
            $error("FAIL ack_timeout: observed no ack after %0d cycles expected ack", n);
        end
        tick(1'b1, data, rdy(mode));
        tick(1'b0, 16'($urandom), rdy(mode));
    endtask

    // Asserts reset mid-cycle and checks that the outputs clear without a
    // clock edge.
    task automatic do_reset();
        rst_b = 1'b1;
        bus.out_req  = 1'b0;
        bus.tx_ready = 1'b0;
        q.delete();
        m_ack  = 1'b0;
        m_busy = 1'b0;
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.out_req  = 1'b0;
        bus.out_data = '0;
        bus.tx_ready = 1'b0;
        @(negedge clk);
        check_outputs();
        // tx_ready while empty must have no effect on tx_valid or level.
        bus.tx_ready = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);

        // Single word
        do_reset();
        tick(1'b1, 16'h00A5, 1'b0);
        chk("single_ack",   32'(bus.out_ack), 32'd1);
        chk("single_valid", 32'(bus.tx_valid), 32'd1);
        chk("single_data",  32'(bus.tx_data), 32'h00A5);
        tick(1'b1, 16'h5A5A, 1'b0);
        chk("single_ack_drop", 32'(bus.out_ack), 32'd0);
        tick(1'b0, 16'h1111, 1'b0);
        chk("single_level", 32'(bus.level), 32'd1);

        // Held request writes exactly once
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, 16'h1234, 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        chk("held_level", 32'(bus.level), 32'd1);

        // Fill, then block the 9th request
        do_reset();
        for (int i = 1; i <= 8; i++) send_word(16'(i), 0);
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_level", 32'(bus.level), 32'd8);
        for (int i = 0; i < 4; i++) tick(1'b1, 16'h0009, 1'b0);
        tick(1'b1, 16'h0009, 1'b1);   // pop edge: still no write
        chk("block_head", 32'(bus.tx_data), 32'h0002);
        tick(1'b1, 16'h0009, 1'b0);   // the write lands now
        chk("block_ack",  32'(bus.out_ack), 32'd1);
        tick(1'b1, 16'h0009, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);
        chk("block_level", 32'(bus.level), 32'd8);

        // Wrap-around and ordering with tx_ready toggling
        do_reset();
        rx.delete();
        for (int i = 1; i <= 20; i++) send_word(16'(i), 2);
        for (int n = 0; n < 100 && bus.tx_valid; n++) tick(1'b0, '0, 1'b1);
        chk("wrap_count", 32'(rx.size()), 32'd20);
        for (int i = 0; i < 20 && i < rx.size(); i++) chk("wrap_order", 32'(rx[i]), 32'(i + 1));
        chk("wrap_empty", 32'(bus.empty), 32'd1);
        chk("wrap_level", 32'(bus.level), 32'd0);

        // Simultaneous write and pop at level 3
        do_reset();
        send_word(16'h0011, 0);
        send_word(16'h0022, 0);
        send_word(16'h0033, 0);
        tick(1'b1, 16'h0044, 1'b1);
        chk("simul_level", 32'(bus.level), 32'd3);
        chk("simul_head",  32'(bus.tx_data), 32'h0022);
        tick(1'b1, 16'h0044, 1'b0);
        tick(1'b0, 16'h0000, 1'b0);

        // Reset in ACK at level 5
        do_reset();
        for (int i = 0; i < 4; i++) send_word(16'($urandom), 0);
        tick(1'b1, 16'h0055, 1'b0);
        chk("pre_rst_ack",   32'(bus.out_ack), 32'd1);
        chk("pre_rst_level", 32'(bus.level), 32'd5);
        do_reset();
        send_word(16'hBEEF, 0);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        chk("post_rst_data",  32'(bus.tx_data), 32'hBEEF);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++)
            tick(bit'($urandom_range(0, 3) != 0), 16'($urandom), bit'($urandom_range(0, 1)));
        for (int n = 0; n < 40; n++) tick(1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
